// File: rtl/spi_cmd_seq_pkg.sv
// Shared definitions for the SPI command sequencer: FSM state type and the
// command byte field layout. Imported by spi_cmd_seq and its testbench.
package spi_cmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_MID,
    ST_ADDR_LO,
    ST_CSR_WR,
    ST_CSR_RD,
    ST_PROM_WR,
    ST_DISCARD
  } state_t;

  // Command byte layout: [7] write, [6] reserved, [5:4] target, [3:0] address high nibble
  localparam int unsigned CMD_WR_BIT  = 7;
  localparam int unsigned CMD_TGT_HI  = 5;
  localparam int unsigned CMD_TGT_LO  = 4;
  localparam int unsigned CMD_NIB_HI  = 3;
  localparam int unsigned CMD_NIB_LO  = 0;

  localparam logic [1:0] TGT_CSR  = 2'b00;
  localparam logic [1:0] TGT_PROM = 2'b01;

endpackage

// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: command sequencer between the SPI byte transceiver and the
// CSR / PROM stores. Decodes the command byte of each ss-framed transaction,
// assembles the address, issues auto-incrementing CSR byte reads/writes and
// packs PROM bytes little-endian into PROM_DW-bit words.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ss                      slave select (synchronised), 1 = no frame
//   rx_data, rx_valid       received byte and its one-cycle valid pulse
//   tx_data, tx_ack         reply byte and its one-cycle latch pulse
//   csr_addr, csr_wdata     CSR byte address / write data
//   csr_wr_en, csr_rd_en    CSR one-cycle strobes
//   csr_rdata               CSR read data, valid the cycle after csr_rd_en
//   prom_addr, prom_wdata   PROM word address / packed word
//   prom_wr_en              PROM one-cycle write strobe
module spi_cmd_seq
  import spi_cmd_seq_pkg::*;
#(
  parameter int CSR_AW  = 12,
  parameter int PROM_AW = 20,
  parameter int PROM_DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ss,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_ack,
  output logic [CSR_AW-1:0]  csr_addr,
  output logic [7:0]         csr_wdata,
  output logic               csr_wr_en,
  output logic               csr_rd_en,
  input  logic [7:0]         csr_rdata,
  output logic [PROM_AW-1:0] prom_addr,
  output logic [PROM_DW-1:0] prom_wdata,
  output logic               prom_wr_en
);

  localparam logic [1:0] LAST_BYTE = 2'(PROM_DW / 8 - 1);

  state_t             state;
  logic               wr_cmd;
  logic               is_prom;
  logic [1:0]         byte_cnt;
  logic [PROM_DW-1:0] pack_sh;
  logic [7:0]         tx_hold;

  // Read data is only valid in the ack cycle, so it is forwarded directly and
  // captured into tx_hold to keep tx_data stable until the next ack.
  assign tx_data = tx_ack ? csr_rdata : tx_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_cmd     <= 1'b0;
      is_prom    <= 1'b0;
      byte_cnt   <= '0;
      pack_sh    <= '0;
      tx_hold    <= '0;
      tx_ack     <= 1'b0;
      csr_addr   <= '0;
      csr_wdata  <= '0;
      csr_wr_en  <= 1'b0;
      csr_rd_en  <= 1'b0;
      prom_addr  <= '0;
      prom_wdata <= '0;
      prom_wr_en <= 1'b0;
    end else begin
      csr_wr_en  <= 1'b0;
      csr_rd_en  <= 1'b0;
      prom_wr_en <= 1'b0;
      tx_ack     <= csr_rd_en & ~ss;

      // Post-increment after each access; a new command byte below overrides.
      if (csr_wr_en || csr_rd_en)
        csr_addr <= csr_addr + CSR_AW'(1);
      if (prom_wr_en)
        prom_addr <= prom_addr + PROM_AW'(1);
      if (tx_ack)
        tx_hold <= csr_rdata;

      if (ss) begin
        // Frame end wins over a coincident byte; partial PROM word dropped.
        state    <= ST_IDLE;
        byte_cnt <= '0;
        tx_hold  <= '0;
        tx_ack   <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            wr_cmd  <= rx_data[CMD_WR_BIT];
            is_prom <= 1'b0;
            if (rx_data[CMD_TGT_HI:CMD_TGT_LO] == TGT_CSR) begin
              csr_addr <= CSR_AW'({rx_data[CMD_NIB_HI:CMD_NIB_LO], 8'h00});
              state    <= ST_ADDR_LO;
            end else if (rx_data[CMD_TGT_HI:CMD_TGT_LO] == TGT_PROM &&
                         rx_data[CMD_WR_BIT]) begin
              is_prom   <= 1'b1;
              prom_addr <= PROM_AW'({rx_data[CMD_NIB_HI:CMD_NIB_LO], 16'h0000});
              state     <= ST_ADDR_MID;
            end else begin
              state <= ST_DISCARD;
            end
          end
          ST_ADDR_MID: begin
            prom_addr[15:8] <= rx_data;
            state           <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            if (is_prom) begin
              prom_addr[7:0] <= rx_data;
              byte_cnt       <= '0;
              state          <= ST_PROM_WR;
            end else begin
              csr_addr[7:0] <= rx_data;
              if (wr_cmd) begin
                state <= ST_CSR_WR;
              end else begin
                // Address byte itself triggers the first read.
                csr_rd_en <= 1'b1;
                state     <= ST_CSR_RD;
              end
            end
          end
          ST_CSR_WR: begin
            csr_wdata <= rx_data;
            csr_wr_en <= 1'b1;
          end
          ST_CSR_RD: begin
            csr_rd_en <= 1'b1;
          end
          ST_PROM_WR: begin
            pack_sh <= {rx_data, pack_sh[PROM_DW-1:8]};
            if (byte_cnt == LAST_BYTE) begin
              prom_wdata <= {rx_data, pack_sh[PROM_DW-1:8]};
              prom_wr_en <= 1'b1;
              byte_cnt   <= '0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          ST_DISCARD: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
